jacobi_pair_scheduler: RTL and testbench
========================================

# jacobi_pair_scheduler

Sweep scheduler for the cyclic Jacobi eigenvalue engine. It generates the ordered sequence of (p,q) pivot index pairs over a configurable number of sweeps and issues one pair at a time to the main controller. With each pair it supplies the precomputed BRAM addresses of a_pp, a_qq and a_pq. It waits for the controller's per-pair completion before advancing, and signals the end of the whole decomposition.

## Interface
- N, default 4: matrix dimension. Legal range is 2..16.
- NUM_SWEEPS, default 6: number of full cyclic sweeps per run. Must be ≥1.
- IDX_WIDTH, default 4: width of the p/q indices. Must satisfy 2^IDX_WIDTH ≥ N.
- ADDR_WIDTH, default JACOBI_ADDR_WIDTH: BRAM word-address width. Must satisfy 2^ADDR_WIDTH ≥ N·N.
- clk  in  1  single clock. All logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle run request. Honoured only in IDLE.
- abort_i  in  1  terminates the run. Takes effect in any state.
- pair_p_o  out  IDX_WIDTH  row index p.
- pair_q_o  out  IDX_WIDTH  column index q. Always q > p.
- addr_pp_o  out  ADDR_WIDTH  address p·N+p.
- addr_qq_o  out  ADDR_WIDTH  address q·N+q.
- addr_pq_o  out  ADDR_WIDTH  address p·N+q.
- pair_vld_o  out  1  pair and address outputs are valid.
- pair_rdy_i  in  1  controller accepts the pair.
- pair_done_i  in  1  controller finished the rotation for the accepted pair. One-cycle pulse.
- sweep_o  out  $clog2(NUM_SWEEPS+1)  index of the current sweep, 0-based.
- busy_o  out  1  high in ISSUE and WAIT.
- done_o  out  1  one-cycle pulse at the end of a completed run.

## Operation
- Pair order within a sweep is row-cyclic: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). That gives N(N-1)/2 pairs per sweep.
- Advance rule:
  - If q < N-1: q←q+1.
  - Else, if p < N-2: p←p+1 and q←p+2.
  - Else the sweep ends: p←0, q←1, sweep←sweep+1.
- Addresses use row-major layout. They are registered in the same cycle as p and q and are computed with no combinational path from inputs. A counter- or shift-add form is acceptable; the result must equal the exact products.
- Only one pair is outstanding at a time. The next pair is never presented before pair_done_i arrives for the current one.
- FSM states are IDLE, ISSUE, WAIT and DONE:
  - IDLE: start_i=1 loads p=0, q=1, sweep=0 and moves to ISSUE.
  - ISSUE: pair_vld_o=1. pair_vld_o && pair_rdy_i moves to WAIT.
  - WAIT: pair_done_i=1 on the last pair of sweep NUM_SWEEPS-1 moves to DONE. On any other pair it advances the indices and moves to ISSUE.
  - DONE: done_o=1 for one cycle, then IDLE.
- abort_i=1 in any state forces IDLE on the next edge. No done_o is produced. Indices and sweep_o hold their current values. abort_i wins over every simultaneous event.
- Ignored inputs:
  - start_i outside IDLE.
  - pair_done_i outside WAIT, including in the same cycle as acceptance in ISSUE.
  - pair_rdy_i outside ISSUE.
- While pair_vld_o=1 and pair_rdy_i=0, all pair and address outputs hold stable.

## Timing
- Reset values: all outputs are 0, except pair_q_o=1 and addr_qq_o=N+1. State is IDLE.
- Reset assertion mid-run returns to the reset state immediately, asynchronously. Deassertion is synchronised by the standard reset bridge outside this block.
- Latencies:
  - start_i sampled at edge k → pair_vld_o high after edge k (visible in cycle k+1).
  - Acceptance at edge k → pair_vld_o low in cycle k+1.
  - pair_done_i at edge k → next pair valid in cycle k+1. Throughput is therefore 1 pair per (controller latency + 2) cycles minimum.
  - The final pair_done_i at edge k → done_o high in cycle k+1, busy_o low in cycle k+1, IDLE in cycle k+2.
- sweep_o increments on the edge that advances past (N-2,N-1). It never reaches NUM_SWEEPS; it holds NUM_SWEEPS-1 through DONE.

## Test plan
- **Full run.** N=4, NUM_SWEEPS=2, rdy tied 1, done pulsed 3 cycles after each accept → 12 pairs in the order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3), repeated twice. For (1,3): addr_pp=5, addr_qq=15, addr_pq=7. Exactly one done_o pulse, after the 12th pair_done_i.
- **Backpressure.** pair_rdy_i held 0 for 5 cycles on pair (0,2) → outputs stable and vld high throughout. Acceptance on the 6th cycle. No duplicate or skipped pair.
- **Abort.** abort_i asserted in WAIT of pair (1,2), sweep 0 → IDLE next cycle, busy_o=0, no done_o. A new start_i restarts at (0,1), sweep 0.
- **Ignored inputs.**
  - start_i pulsed during WAIT → no effect on the sequence.
  - pair_done_i pulsed in IDLE → no effect.
  - pair_done_i pulsed in ISSUE → does not advance the sequence.
- **Asynchronous reset mid-run.** rst driven low between clock edges in ISSUE → outputs take their reset values without a clock edge.
- **Minimum size.** N=2, NUM_SWEEPS=3 → three (0,1) pairs with addresses 0, 3 and 1. sweep_o steps 0→1→2. Single done_o pulse.

Source files
------------

// File: rtl/jacobi_pair_scheduler_if.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler_if
// Pair hand-off bus between the Jacobi sweep scheduler and the main rotation
// controller.
//   pair_p_o / pair_q_o     : pivot indices, q > p
//   addr_pp_o / addr_qq_o /
//   addr_pq_o               : row-major BRAM word addresses of a_pp, a_qq, a_pq
//   pair_vld_o              : pair and addresses are valid
//   pair_rdy_i              : controller accepts the presented pair
//   pair_done_i             : one-cycle pulse, rotation for accepted pair done
// master = scheduler side, slave = controller side.
// -----------------------------------------------------------------------------
interface jacobi_pair_scheduler_if #(
    parameter int IDX_WIDTH  = 4,
    parameter int ADDR_WIDTH = 8
);
    logic [IDX_WIDTH-1:0]  pair_p_o;
    logic [IDX_WIDTH-1:0]  pair_q_o;
    logic [ADDR_WIDTH-1:0] addr_pp_o;
    logic [ADDR_WIDTH-1:0] addr_qq_o;
    logic [ADDR_WIDTH-1:0] addr_pq_o;
    logic                  pair_vld_o;
    logic                  pair_rdy_i;
    logic                  pair_done_i;

    modport master (
        output pair_p_o, pair_q_o, addr_pp_o, addr_qq_o, addr_pq_o, pair_vld_o,
        input  pair_rdy_i, pair_done_i
    );

    modport slave (
        input  pair_p_o, pair_q_o, addr_pp_o, addr_qq_o, addr_pq_o, pair_vld_o,
        output pair_rdy_i, pair_done_i
    );
endinterface

// File: rtl/jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// jacobi_pair_scheduler
// Generates the row-cyclic (p,q) pivot sequence for NUM_SWEEPS sweeps of the
// cyclic Jacobi eigenvalue engine, one pair outstanding at a time, together
// with the row-major BRAM addresses of a_pp, a_qq and a_pq.
// Ports:
//   clk       : single rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start_i   : one-cycle run request, honoured only in IDLE
//   abort_i   : return to IDLE on the next edge, highest priority
//   bus       : pair hand-off bus (master side)
//   sweep_o   : current sweep index, 0-based
//   busy_o    : high while issuing or waiting on a pair
//   done_o    : one-cycle pulse at the end of a completed run
// ADDR_WIDTH defaults to the engine's BRAM word-address width (8 bits covers
// the largest 16x16 matrix).
// -----------------------------------------------------------------------------
module jacobi_pair_scheduler #(
    parameter  int N           = 4,
    parameter  int NUM_SWEEPS  = 6,
    parameter  int IDX_WIDTH   = 4,
    parameter  int ADDR_WIDTH  = 8,
    localparam int SWEEP_WIDTH = $clog2(NUM_SWEEPS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    jacobi_pair_scheduler_if.master    bus,
    output logic [SWEEP_WIDTH-1:0]     sweep_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Diagonal stride: moving one row and one column down adds N+1.
    localparam logic [ADDR_WIDTH-1:0]  DIAG_STEP  = ADDR_WIDTH'(N + 1);
    localparam logic [IDX_WIDTH-1:0]   P_LAST     = IDX_WIDTH'(N - 2);
    localparam logic [IDX_WIDTH-1:0]   Q_LAST     = IDX_WIDTH'(N - 1);
    localparam logic [SWEEP_WIDTH-1:0] SWEEP_LAST = SWEEP_WIDTH'(NUM_SWEEPS - 1);

    state_e                  state_q,   state_d;
    logic [IDX_WIDTH-1:0]    pair_p_q,  pair_p_d;
    logic [IDX_WIDTH-1:0]    pair_q_q,  pair_q_d;
    logic [ADDR_WIDTH-1:0]   addr_pp_q, addr_pp_d;
    logic [ADDR_WIDTH-1:0]   addr_qq_q, addr_qq_d;
    logic [ADDR_WIDTH-1:0]   addr_pq_q, addr_pq_d;
    logic [SWEEP_WIDTH-1:0]  sweep_q,   sweep_d;
    logic                    vld_q,     vld_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;
    logic                    last_pair_s;

    // Final pair of the final sweep ends the run instead of advancing.
    assign last_pair_s = (pair_p_q == P_LAST) && (pair_q_q == Q_LAST) &&
                         (sweep_q == SWEEP_LAST);

    // Next-state, index advance and incremental address update.
    always_comb begin
        state_d   = state_q;
        pair_p_d  = pair_p_q;
        pair_q_d  = pair_q_q;
        addr_pp_d = addr_pp_q;
        addr_qq_d = addr_qq_q;
        addr_pq_d = addr_pq_q;
        sweep_d   = sweep_q;
        vld_d     = vld_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_ISSUE;
                    pair_p_d  = {IDX_WIDTH{1'b0}};
                    pair_q_d  = IDX_WIDTH'(1);
                    addr_pp_d = {ADDR_WIDTH{1'b0}};
                    addr_qq_d = DIAG_STEP;
                    addr_pq_d = ADDR_WIDTH'(1);
                    sweep_d   = {SWEEP_WIDTH{1'b0}};
                    vld_d     = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                // pair_done_i is deliberately not looked at here.
                if (bus.pair_rdy_i) begin
                    state_d = ST_WAIT;
                    vld_d   = 1'b0;
                end else begin
                    state_d = ST_ISSUE;
                    vld_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.pair_done_i) begin
                    if (last_pair_s) begin
                        // Indices and sweep hold their final values through DONE.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        vld_d   = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                        vld_d   = 1'b1;
                        if (pair_q_q != Q_LAST) begin
                            // Same row, next column.
                            pair_q_d  = pair_q_q + IDX_WIDTH'(1);
                            addr_qq_d = addr_qq_q + DIAG_STEP;
                            addr_pq_d = addr_pq_q + ADDR_WIDTH'(1);
                        end else if (pair_p_q != P_LAST) begin
                            // Next row: new p = p+1, new q = p+2, so
                            // pq sits one word right of the new pp and
                            // qq is one diagonal step beyond it.
                            pair_p_d  = pair_p_q + IDX_WIDTH'(1);
                            pair_q_d  = pair_p_q + IDX_WIDTH'(2);
                            addr_pp_d = addr_pp_q + DIAG_STEP;
                            addr_qq_d = addr_pp_q + DIAG_STEP + DIAG_STEP;
                            addr_pq_d = addr_pp_q + DIAG_STEP + ADDR_WIDTH'(1);
                        end else begin
                            // Sweep wrap back to (0,1).
                            pair_p_d  = {IDX_WIDTH{1'b0}};
                            pair_q_d  = IDX_WIDTH'(1);
                            addr_pp_d = {ADDR_WIDTH{1'b0}};
                            addr_qq_d = DIAG_STEP;
                            addr_pq_d = ADDR_WIDTH'(1);
                            sweep_d   = sweep_q + SWEEP_WIDTH'(1);
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                    vld_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything: back to IDLE, indices frozen, no done.
        if (abort_i) begin
            state_d   = ST_IDLE;
            pair_p_d  = pair_p_q;
            pair_q_d  = pair_q_q;
            addr_pp_d = addr_pp_q;
            addr_qq_d = addr_qq_q;
            addr_pq_d = addr_pq_q;
            sweep_d   = sweep_q;
            vld_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pair_p_q  <= {IDX_WIDTH{1'b0}};
            pair_q_q  <= IDX_WIDTH'(1);
            addr_pp_q <= {ADDR_WIDTH{1'b0}};
            addr_qq_q <= DIAG_STEP;
            addr_pq_q <= {ADDR_WIDTH{1'b0}};
            sweep_q   <= {SWEEP_WIDTH{1'b0}};
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pair_p_q  <= pair_p_d;
            pair_q_q  <= pair_q_d;
            addr_pp_q <= addr_pp_d;
            addr_qq_q <= addr_qq_d;
            addr_pq_q <= addr_pq_d;
            sweep_q   <= sweep_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.pair_p_o   = pair_p_q;
    assign bus.pair_q_o   = pair_q_q;
    assign bus.addr_pp_o  = addr_pp_q;
    assign bus.addr_qq_o  = addr_qq_q;
    assign bus.addr_pq_o  = addr_pq_q;
    assign bus.pair_vld_o = vld_q;
    assign sweep_o        = sweep_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// -----------------------------------------------------------------------------
// tb_jacobi_pair_scheduler
// Two instances: A (N=4, 2 sweeps) and B (N=2, 3 sweeps). Expected pairs come
// from a nested-loop list of (sweep,p,q) and addresses from plain products.
// -----------------------------------------------------------------------------
module tb_jacobi_pair_scheduler;
    localparam int NA  = 4;
    localparam int SA  = 2;
    localparam int NB  = 2;
    localparam int SB  = 3;
    localparam int IW  = 4;
    localparam int AW  = 8;
    localparam int SWA = $clog2(SA + 1);
    localparam int SWB = $clog2(SB + 1);

    typedef struct {
        int s;
        int p;
        int q;
    } pair_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [SWA-1:0] sweep_a;
    logic [SWB-1:0] sweep_b;
    logic busy_a, done_a, busy_b, done_b;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt_a  = 0;
    int done_cnt_b  = 0;
    pair_t exp_q[$];

    jacobi_pair_scheduler_if #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW)) bus_a ();
    jacobi_pair_scheduler_if #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW)) bus_b ();

    jacobi_pair_scheduler #(.N(NA), .NUM_SWEEPS(SA), .IDX_WIDTH(IW), .ADDR_WIDTH(AW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
        .bus(bus_a), .sweep_o(sweep_a), .busy_o(busy_a), .done_o(done_a)
    );

    jacobi_pair_scheduler #(.N(NB), .NUM_SWEEPS(SB), .IDX_WIDTH(IW), .ADDR_WIDTH(AW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
        .bus(bus_b), .sweep_o(sweep_b), .busy_o(busy_b), .done_o(done_b)
    );

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference sequence: every sweep visits all p<q in row order.
    task automatic build_model(input int n, input int ns);
        pair_t e;
        exp_q.delete();
        for (int s = 0; s < ns; s++)
            for (int p = 0; p < n - 1; p++)
                for (int q = p + 1; q < n; q++) begin
                    e.s = s; e.p = p; e.q = q;
                    exp_q.push_back(e);
                end
    endtask

    // Stimulus only: accept the presented pair on A and complete it after lat cycles.
    task automatic accept_pair_a(input int lat);
        bus_a.pair_rdy_i = 1'b1;
        tick;
        bus_a.pair_rdy_i = 1'b0;
        repeat (lat) tick;
        bus_a.pair_done_i = 1'b1;
        tick;
        bus_a.pair_done_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        vectors++;
        if ({bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o, bus_a.addr_qq_o, bus_a.addr_pq_o,
             bus_a.pair_vld_o, busy_a, done_a, sweep_a} !==
            {IW'(0), IW'(1), AW'(0), AW'(NA + 1), AW'(0), 1'b0, 1'b0, 1'b0, SWA'(0)}) begin
            miscompares++;
            $display("FAIL reset_a: got p=%0d q=%0d pp=%0d qq=%0d pq=%0d vld=%0b busy=%0b done=%0b sw=%0d, want 0 1 0 %0d 0 0 0 0 0",
                     bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o, bus_a.addr_qq_o, bus_a.addr_pq_o,
                     bus_a.pair_vld_o, busy_a, done_a, sweep_a, NA + 1);
        end
        vectors++;
        if (bus_b.addr_qq_o !== AW'(NB + 1) || bus_b.pair_q_o !== IW'(1) || bus_b.pair_vld_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b: got q=%0d qq=%0d vld=%0b, want 1 %0d 0",
                     bus_b.pair_q_o, bus_b.addr_qq_o, bus_b.pair_vld_o, NB + 1);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_full_run(input bit rnd);
        pair_t e;
        int hold, lat, d0;
        bit last;
        build_model(NA, SA);
        d0 = done_cnt_a;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            last = (i == exp_q.size() - 1);
            vectors++;
            if (bus_a.pair_vld_o !== 1'b1 || busy_a !== 1'b1 || bus_a.pair_p_o !== IW'(e.p) ||
                bus_a.pair_q_o !== IW'(e.q) || bus_a.addr_pp_o !== AW'(e.p * NA + e.p) ||
                bus_a.addr_qq_o !== AW'(e.q * NA + e.q) || bus_a.addr_pq_o !== AW'(e.p * NA + e.q) ||
                sweep_a !== SWA'(e.s)) begin
                miscompares++;
                $display("FAIL full_run pair %0d: got vld=%0b p=%0d q=%0d pp=%0d qq=%0d pq=%0d sw=%0d, want vld=1 p=%0d q=%0d pp=%0d qq=%0d pq=%0d sw=%0d",
                         i, bus_a.pair_vld_o, bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o,
                         bus_a.addr_qq_o, bus_a.addr_pq_o, sweep_a, e.p, e.q,
                         e.p * NA + e.p, e.q * NA + e.q, e.p * NA + e.q, e.s);
            end
            hold = rnd ? $urandom_range(0, 3) : 0;
            for (int h = 0; h < hold; h++) begin
                bus_a.pair_rdy_i  = 1'b0;
                bus_a.pair_done_i = rnd & 1'($urandom_range(0, 1));
                tick;
                bus_a.pair_done_i = 1'b0;
                vectors++;
                if (bus_a.pair_vld_o !== 1'b1 || bus_a.pair_p_o !== IW'(e.p) || bus_a.pair_q_o !== IW'(e.q) ||
                    bus_a.addr_pq_o !== AW'(e.p * NA + e.q)) begin
                    miscompares++;
                    $display("FAIL stall pair %0d: got vld=%0b p=%0d q=%0d pq=%0d, want 1 %0d %0d %0d",
                             i, bus_a.pair_vld_o, bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pq_o,
                             e.p, e.q, e.p * NA + e.q);
                end
            end
            bus_a.pair_rdy_i  = 1'b1;
            bus_a.pair_done_i = rnd & 1'($urandom_range(0, 1));
            tick;
            bus_a.pair_rdy_i  = 1'b0;
            bus_a.pair_done_i = 1'b0;
            vectors++;
            if (bus_a.pair_vld_o !== 1'b0 || busy_a !== 1'b1) begin
                miscompares++;
                $display("FAIL accept pair %0d: got vld=%0b busy=%0b, want 0 1", i, bus_a.pair_vld_o, busy_a);
            end
            lat = rnd ? $urandom_range(0, 4) : 2;
            for (int l = 0; l < lat; l++) begin
                start_a          = rnd & 1'($urandom_range(0, 1));
                bus_a.pair_rdy_i = rnd & 1'($urandom_range(0, 1));
                tick;
                start_a          = 1'b0;
                bus_a.pair_rdy_i = 1'b0;
                vectors++;
                if (bus_a.pair_vld_o !== 1'b0 || busy_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wait pair %0d: got vld=%0b busy=%0b, want 0 1", i, bus_a.pair_vld_o, busy_a);
                end
            end
            bus_a.pair_done_i = 1'b1;
            tick;
            bus_a.pair_done_i = 1'b0;
            if (last) begin
                vectors++;
                if (done_a !== 1'b1 || busy_a !== 1'b0 || bus_a.pair_vld_o !== 1'b0 || sweep_a !== SWA'(SA - 1)) begin
                    miscompares++;
                    $display("FAIL done_pulse: got done=%0b busy=%0b vld=%0b sw=%0d, want 1 0 0 %0d",
                             done_a, busy_a, bus_a.pair_vld_o, sweep_a, SA - 1);
                end
                tick;
                vectors++;
                if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL after_done: got done=%0b busy=%0b, want 0 0", done_a, busy_a);
                end
            end
        end
        vectors++;
        if (done_cnt_a - d0 != 1) begin
            miscompares++;
            $display("FAIL done_count: got %0d pulses, want 1", done_cnt_a - d0);
        end
    endtask

    // Leaves instance A in WAIT of pair (1,2), sweep 0.
    task automatic test_backpressure;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        accept_pair_a(1);
        for (int c = 0; c < 5; c++) begin
            bus_a.pair_rdy_i = 1'b0;
            tick;
            vectors++;
            if (bus_a.pair_vld_o !== 1'b1 || bus_a.pair_p_o !== IW'(0) || bus_a.pair_q_o !== IW'(2) ||
                bus_a.addr_pp_o !== AW'(0) || bus_a.addr_qq_o !== AW'(10) || bus_a.addr_pq_o !== AW'(2)) begin
                miscompares++;
                $display("FAIL backpressure cycle %0d: got vld=%0b p=%0d q=%0d pp=%0d qq=%0d pq=%0d, want 1 0 2 0 10 2",
                         c, bus_a.pair_vld_o, bus_a.pair_p_o, bus_a.pair_q_o,
                         bus_a.addr_pp_o, bus_a.addr_qq_o, bus_a.addr_pq_o);
            end
        end
        accept_pair_a(0);
        vectors++;
        if (bus_a.pair_vld_o !== 1'b1 || bus_a.pair_p_o !== IW'(0) || bus_a.pair_q_o !== IW'(3) ||
            bus_a.addr_qq_o !== AW'(15) || bus_a.addr_pq_o !== AW'(3)) begin
            miscompares++;
            $display("FAIL bp_next: got vld=%0b p=%0d q=%0d qq=%0d pq=%0d, want 1 0 3 15 3",
                     bus_a.pair_vld_o, bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_qq_o, bus_a.addr_pq_o);
        end
        accept_pair_a(0);
        vectors++;
        if (bus_a.pair_p_o !== IW'(1) || bus_a.pair_q_o !== IW'(2) || bus_a.addr_pp_o !== AW'(5) ||
            bus_a.addr_qq_o !== AW'(10) || bus_a.addr_pq_o !== AW'(6)) begin
            miscompares++;
            $display("FAIL row_wrap: got p=%0d q=%0d pp=%0d qq=%0d pq=%0d, want 1 2 5 10 6",
                     bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o, bus_a.addr_qq_o, bus_a.addr_pq_o);
        end
        bus_a.pair_rdy_i = 1'b1;
        tick;
        bus_a.pair_rdy_i = 1'b0;
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_cnt_a;
        abort_a = 1'b1;
        bus_a.pair_done_i = 1'b1;
        tick;
        abort_a = 1'b0;
        bus_a.pair_done_i = 1'b0;
        vectors++;
        if (busy_a !== 1'b0 || bus_a.pair_vld_o !== 1'b0 || done_a !== 1'b0 || bus_a.pair_p_o !== IW'(1) ||
            bus_a.pair_q_o !== IW'(2) || bus_a.addr_pq_o !== AW'(6) || sweep_a !== SWA'(0)) begin
            miscompares++;
            $display("FAIL abort: got busy=%0b vld=%0b done=%0b p=%0d q=%0d pq=%0d sw=%0d, want 0 0 0 1 2 6 0",
                     busy_a, bus_a.pair_vld_o, done_a, bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pq_o, sweep_a);
        end
        bus_a.pair_done_i = 1'b1;
        tick;
        bus_a.pair_done_i = 1'b0;
        tick;
        vectors++;
        if (busy_a !== 1'b0 || bus_a.pair_vld_o !== 1'b0 || done_cnt_a != d0) begin
            miscompares++;
            $display("FAIL idle_done_ignored: got busy=%0b vld=%0b done_pulses=%0d, want 0 0 0",
                     busy_a, bus_a.pair_vld_o, done_cnt_a - d0);
        end
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        vectors++;
        if (bus_a.pair_vld_o !== 1'b1 || bus_a.pair_p_o !== IW'(0) || bus_a.pair_q_o !== IW'(1) ||
            bus_a.addr_pp_o !== AW'(0) || bus_a.addr_qq_o !== AW'(5) || bus_a.addr_pq_o !== AW'(1) ||
            sweep_a !== SWA'(0)) begin
            miscompares++;
            $display("FAIL restart: got vld=%0b p=%0d q=%0d pp=%0d qq=%0d pq=%0d sw=%0d, want 1 0 1 0 5 1 0",
                     bus_a.pair_vld_o, bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o,
                     bus_a.addr_qq_o, bus_a.addr_pq_o, sweep_a);
        end
    endtask

    // Starts with instance A in ISSUE of (0,1).
    task automatic test_ignored_inputs;
        bus_a.pair_done_i = 1'b1;
        tick;
        bus_a.pair_done_i = 1'b0;
        vectors++;
        if (bus_a.pair_vld_o !== 1'b1 || bus_a.pair_q_o !== IW'(1)) begin
            miscompares++;
            $display("FAIL done_in_issue: got vld=%0b q=%0d, want 1 1", bus_a.pair_vld_o, bus_a.pair_q_o);
        end
        bus_a.pair_rdy_i  = 1'b1;
        bus_a.pair_done_i = 1'b1;
        tick;
        bus_a.pair_rdy_i  = 1'b0;
        bus_a.pair_done_i = 1'b0;
        tick; tick;
        vectors++;
        if (bus_a.pair_vld_o !== 1'b0 || busy_a !== 1'b1 || bus_a.pair_q_o !== IW'(1)) begin
            miscompares++;
            $display("FAIL done_at_accept: got vld=%0b busy=%0b q=%0d, want 0 1 1",
                     bus_a.pair_vld_o, busy_a, bus_a.pair_q_o);
        end
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        vectors++;
        if (bus_a.pair_vld_o !== 1'b0 || busy_a !== 1'b1 || bus_a.pair_q_o !== IW'(1)) begin
            miscompares++;
            $display("FAIL start_in_wait: got vld=%0b busy=%0b q=%0d, want 0 1 1",
                     bus_a.pair_vld_o, busy_a, bus_a.pair_q_o);
        end
        bus_a.pair_done_i = 1'b1;
        tick;
        bus_a.pair_done_i = 1'b0;
        vectors++;
        if (bus_a.pair_vld_o !== 1'b1 || bus_a.pair_p_o !== IW'(0) || bus_a.pair_q_o !== IW'(2)) begin
            miscompares++;
            $display("FAIL advance_after_wait: got vld=%0b p=%0d q=%0d, want 1 0 2",
                     bus_a.pair_vld_o, bus_a.pair_p_o, bus_a.pair_q_o);
        end
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
    endtask

    task automatic test_async_reset;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        accept_pair_a(1);
        accept_pair_a(0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o, bus_a.addr_qq_o, bus_a.addr_pq_o,
             bus_a.pair_vld_o, busy_a, done_a, sweep_a} !==
            {IW'(0), IW'(1), AW'(0), AW'(NA + 1), AW'(0), 1'b0, 1'b0, 1'b0, SWA'(0)}) begin
            miscompares++;
            $display("FAIL async_reset: got p=%0d q=%0d pp=%0d qq=%0d pq=%0d vld=%0b busy=%0b, want 0 1 0 5 0 0 0",
                     bus_a.pair_p_o, bus_a.pair_q_o, bus_a.addr_pp_o, bus_a.addr_qq_o,
                     bus_a.addr_pq_o, bus_a.pair_vld_o, busy_a);
        end
        rst_n = 1'b1;
        tick;
        vectors++;
        if (busy_a !== 1'b0 || bus_a.pair_vld_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got busy=%0b vld=%0b, want 0 0", busy_a, bus_a.pair_vld_o);
        end
    endtask

    task automatic test_min_size;
        pair_t e;
        int d0, lat;
        build_model(NB, SB);
        d0 = done_cnt_b;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            vectors++;
            if (bus_b.pair_vld_o !== 1'b1 || bus_b.pair_p_o !== IW'(e.p) || bus_b.pair_q_o !== IW'(e.q) ||
                bus_b.addr_pp_o !== AW'(e.p * NB + e.p) || bus_b.addr_qq_o !== AW'(e.q * NB + e.q) ||
                bus_b.addr_pq_o !== AW'(e.p * NB + e.q) || sweep_b !== SWB'(e.s)) begin
                miscompares++;
                $display("FAIL min_size pair %0d: got vld=%0b p=%0d q=%0d pp=%0d qq=%0d pq=%0d sw=%0d, want 1 %0d %0d %0d %0d %0d %0d",
                         i, bus_b.pair_vld_o, bus_b.pair_p_o, bus_b.pair_q_o, bus_b.addr_pp_o,
                         bus_b.addr_qq_o, bus_b.addr_pq_o, sweep_b, e.p, e.q,
                         e.p * NB + e.p, e.q * NB + e.q, e.p * NB + e.q, e.s);
            end
            bus_b.pair_rdy_i = 1'b1;
            tick;
            bus_b.pair_rdy_i = 1'b0;
            lat = $urandom_range(0, 3);
            repeat (lat) tick;
            bus_b.pair_done_i = 1'b1;
            tick;
            bus_b.pair_done_i = 1'b0;
        end
        vectors++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || sweep_b !== SWB'(SB - 1)) begin
            miscompares++;
            $display("FAIL min_size_done: got done=%0b busy=%0b sw=%0d, want 1 0 %0d", done_b, busy_b, sweep_b, SB - 1);
        end
        tick;
        vectors++;
        if (done_cnt_b - d0 != 1 || done_b !== 1'b0) begin
            miscompares++;
            $display("FAIL min_size_count: got %0d pulses done=%0b, want 1 0", done_cnt_b - d0, done_b);
        end
    endtask

    initial begin
        bus_a.pair_rdy_i  = 1'b0;
        bus_a.pair_done_i = 1'b0;
        bus_b.pair_rdy_i  = 1'b0;
        bus_b.pair_done_i = 1'b0;
        test_reset;
        test_full_run(1'b0);
        for (int r = 0; r < 3; r++) test_full_run(1'b1);
        test_backpressure;
        test_abort;
        test_ignored_inputs;
        test_async_reset;
        test_min_size;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
